// File: rtl/bp_stream_mmio_mw.sv
// bp_stream_mmio_mw: BedRock I/O cmd (io_cmd_*) -> word stream (stream_*_o), inbound stream (stream_*_i) -> in-order io_resp_*; clk_i, sync reset_i
module bp_stream_mmio_mw_fifo #(
  parameter int width_p = 8,
  parameter int els_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);
  localparam int pw = els_p > 1 ? $clog2(els_p) : 1;
  logic [width_p-1:0] mem [els_p];
  logic [pw-1:0] rp, wp;
  logic [pw:0] cnt;
  logic enq, deq;
  assign v_o = cnt != '0;
  assign deq = yumi_i & v_o;
  assign ready_o = (cnt != (pw+1)'(els_p)) | deq;
  assign enq = v_i & ready_o;
  assign data_o = mem[rp];
  always_ff @(posedge clk_i) begin
    if (enq) mem[wp] <= data_i;
    if (reset_i) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (enq) wp <= wp == pw'(els_p-1) ? '0 : wp + 1'b1;
      if (deq) rp <= rp == pw'(els_p-1) ? '0 : rp + 1'b1;
      cnt <= cnt + (pw+1)'(enq) - (pw+1)'(deq);
    end
  end
endmodule

module bp_stream_mmio_mw #(
  parameter int paddr_width_p = 40,
  parameter int stream_data_width_p = 32,
  parameter int payload_width_p = 512,
  parameter int outstanding_els_p = 16,
  localparam int mem_header_width_lp = paddr_width_p + 7
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [mem_header_width_lp-1:0] io_cmd_header_i,
  input  logic [payload_width_p-1:0]     io_cmd_data_i,
  input  logic                           io_cmd_v_i,
  output logic                           io_cmd_ready_o,
  output logic [mem_header_width_lp-1:0] io_resp_header_o,
  output logic [payload_width_p-1:0]     io_resp_data_o,
  output logic                           io_resp_v_o,
  input  logic                           io_resp_yumi_i,
  output logic                           stream_v_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  input  logic                           stream_yumi_i,
  input  logic                           stream_v_i,
  input  logic [stream_data_width_p-1:0] stream_data_i,
  output logic                           stream_ready_o
);
  localparam int hw = mem_header_width_lp;
  localparam int sw = stream_data_width_p;
  localparam int aw = (paddr_width_p + sw - 1) / sw;
  localparam int aws = aw * sw;
  localparam int pwd = payload_width_p / sw;
  localparam int cw = $clog2((aw > pwd ? aw : pwd) + 1);
  localparam int rw = $clog2(pwd + 1);
  typedef enum logic [1:0] {TX_IDLE, TX_ADDR, TX_DATA} tx_e;
  function automatic logic [rw-1:0] dwords(input logic [2:0] s);
    int b;
    b = (8 << s) / sw;
    return rw'(b < 1 ? 1 : b > pwd ? pwd : b);
  endfunction
  tx_e state, state_n;
  logic [cw-1:0] cnt, cnt_n;
  logic [hw-1:0] cmd_hdr, head_hdr;
  logic [payload_width_p-1:0] cmd_data, rdata, rdata_n;
  logic [sw-1:0] out_word;
  logic [aws-1:0] addr_ext;
  logic [rw-1:0] rcnt, rcnt_n, cmd_dw, head_dw;
  logic cmd_fifo_ready, cmd_v, cmd_yumi, out_v, out_ready, pend_v, pend_ready;
  logic head_v, pend_yumi, resp_push, resp_ready, cmd_wr, cmd_rd, head_rd, rx_fire, last;
  assign io_cmd_ready_o = cmd_fifo_ready & ~reset_i;
  bp_stream_mmio_mw_fifo #(.width_p(hw + payload_width_p), .els_p(2)) cmd_fifo (
    .clk_i, .reset_i, .data_i({io_cmd_header_i, io_cmd_data_i}), .v_i(io_cmd_v_i & io_cmd_ready_o),
    .ready_o(cmd_fifo_ready), .data_o({cmd_hdr, cmd_data}), .v_o(cmd_v), .yumi_i(cmd_yumi)
  );
  assign cmd_wr = cmd_hdr[3:0] == 4'd1 || cmd_hdr[3:0] == 4'd3;
  assign cmd_rd = cmd_hdr[3:0] == 4'd0 || cmd_hdr[3:0] == 4'd2;
  assign cmd_dw = dwords(cmd_hdr[6:4]);
  assign addr_ext = aws'(cmd_hdr[hw-1:7]);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    out_v = 1'b0;
    out_word = '0;
    pend_v = 1'b0;
    cmd_yumi = 1'b0;
    last = 1'b0;
    if (state == TX_IDLE) begin
      if (cmd_v & out_ready & pend_ready) begin
        out_v = 1'b1;
        out_word = sw'(cmd_hdr[6:0]);
        pend_v = 1'b1;
        cmd_yumi = ~(cmd_wr | cmd_rd);
        state_n = cmd_yumi ? TX_IDLE : TX_ADDR;
      end
    end else if (out_ready) begin
      out_v = 1'b1;
      out_word = state == TX_ADDR ? addr_ext[cnt*sw +: sw] : cmd_data[cnt*sw +: sw];
      last = state == TX_ADDR ? cnt + 1'b1 == cw'(aw) : cnt + 1'b1 == cw'(cmd_dw);
      state_n = !last ? state : (state == TX_ADDR && cmd_wr) ? TX_DATA : TX_IDLE;
      cmd_yumi = last && state_n == TX_IDLE;
      cnt_n = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    state <= reset_i ? TX_IDLE : state_n;
    cnt <= (reset_i || state_n != state) ? '0 : cnt_n;
  end
  bp_stream_mmio_mw_fifo #(.width_p(sw), .els_p(2)) out_fifo (
    .clk_i, .reset_i, .data_i(out_word), .v_i(out_v), .ready_o(out_ready),
    .data_o(stream_data_o), .v_o(stream_v_o), .yumi_i(stream_yumi_i)
  );
  bp_stream_mmio_mw_fifo #(.width_p(hw), .els_p(outstanding_els_p)) pend_fifo (
    .clk_i, .reset_i, .data_i(cmd_hdr), .v_i(pend_v), .ready_o(pend_ready),
    .data_o(head_hdr), .v_o(head_v), .yumi_i(pend_yumi)
  );
  assign head_rd = head_v && (head_hdr[3:0] == 4'd0 || head_hdr[3:0] == 4'd2);
  assign head_dw = dwords(head_hdr[6:4]);
  assign stream_ready_o = head_rd && rcnt < head_dw;
  assign rx_fire = stream_v_i & stream_ready_o;
  assign rcnt_n = rcnt + rw'(rx_fire);
  // the final word is merged combinationally so the response enqueues in the same cycle it arrives
  always_comb begin
    rdata_n = rdata;
    if (rx_fire) rdata_n[rcnt*sw +: sw] = stream_data_i;
  end
  assign resp_push = head_v && (!head_rd || rcnt_n == head_dw);
  assign pend_yumi = resp_push & resp_ready;
  always_ff @(posedge clk_i) begin
    rcnt <= (reset_i || pend_yumi) ? '0 : rcnt_n;
    rdata <= (reset_i || pend_yumi) ? '0 : rdata_n;
  end
  bp_stream_mmio_mw_fifo #(.width_p(hw + payload_width_p), .els_p(2)) resp_fifo (
    .clk_i, .reset_i, .data_i({head_hdr, head_rd ? rdata_n : '0}), .v_i(resp_push), .ready_o(resp_ready),
    .data_o({io_resp_header_o, io_resp_data_o}), .v_o(io_resp_v_o), .yumi_i(io_resp_yumi_i)
  );
endmodule

// File: tb/tb_bp_stream_mmio_mw.sv
// tb_bp_stream_mmio_mw: scoreboard bench for bp_stream_mmio_mw (width 32, paddr 40, payload 512, depth 16)
module tb_bp_stream_mmio_mw;
  localparam int hw = 47;
  localparam int pw = 512;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic [hw-1:0] io_cmd_header_i, io_resp_header_o;
  logic [pw-1:0] io_cmd_data_i, io_resp_data_o;
  logic io_cmd_v_i, io_cmd_ready_o, io_resp_v_o, io_resp_yumi_i;
  logic stream_v_o, stream_yumi_i, stream_v_i, stream_ready_o;
  logic [31:0] stream_data_o, stream_data_i;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_out[$];
  logic [hw-1:0] exp_hdr[$];
  logic [pw-1:0] exp_data[$];
  always #5 clk_i = ~clk_i;
  bp_stream_mmio_mw dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .io_cmd_header_i(io_cmd_header_i), .io_cmd_data_i(io_cmd_data_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .io_resp_header_o(io_resp_header_o), .io_resp_data_o(io_resp_data_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
    .stream_v_o(stream_v_o), .stream_data_o(stream_data_o), .stream_yumi_i(stream_yumi_i),
    .stream_v_i(stream_v_i), .stream_data_i(stream_data_i), .stream_ready_o(stream_ready_o)
  );
  task automatic check(input string name, input logic [pw-1:0] act, input logic [pw-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask
  function automatic int bdw(input logic [2:0] s);
    int b;
    b = (8 << s) / 32;
    return b < 1 ? 1 : (b > 16 ? 16 : b);
  endfunction
  function automatic logic [hw-1:0] mk(input logic [39:0] a, input logic [2:0] s, input logic [3:0] t);
    return {a, s, t};
  endfunction
  always @(negedge clk_i) begin
    if (!reset_i && stream_v_o && stream_yumi_i) begin
      if (exp_out.size() == 0) timeout("stream_unexpected_word");
      else check("stream_word", pw'(stream_data_o), pw'(exp_out.pop_front()));
    end
    if (!reset_i && io_resp_v_o && io_resp_yumi_i) begin
      if (exp_hdr.size() == 0) timeout("resp_unexpected");
      else begin
        check("resp_hdr", pw'(io_resp_header_o), pw'(exp_hdr.pop_front()));
        check("resp_data", io_resp_data_o, exp_data.pop_front());
      end
    end
  end
  task automatic send_cmd(input logic [hw-1:0] h, input logic [pw-1:0] d, input logic [pw-1:0] rd_exp);
    logic [63:0] a;
    int n;
    logic rd, wr;
    rd = h[3:0] == 4'd0 || h[3:0] == 4'd2;
    wr = h[3:0] == 4'd1 || h[3:0] == 4'd3;
    a = 64'(h[hw-1:7]);
    exp_out.push_back({25'd0, h[6:0]});
    if (rd || wr) begin
      exp_out.push_back(a[31:0]);
      exp_out.push_back(a[63:32]);
    end
    if (wr) for (int i = 0; i < bdw(h[6:4]); i++) exp_out.push_back(d[i*32 +: 32]);
    exp_hdr.push_back(h);
    exp_data.push_back(rd ? rd_exp : '0);
    io_cmd_header_i = h;
    io_cmd_data_i = d;
    io_cmd_v_i = 1'b1;
    n = 0;
    while (!io_cmd_ready_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 1000) timeout("cmd_accept");
    @(negedge clk_i);
    io_cmd_v_i = 1'b0;
  endtask
  task automatic push_in(input logic [31:0] w);
    int n;
    stream_v_i = 1'b1;
    stream_data_i = w;
    n = 0;
    while (!stream_ready_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 1000) timeout("stream_in_accept");
    @(negedge clk_i);
    stream_v_i = 1'b0;
  endtask
  task automatic wait_idle(input string name, input bit out_only);
    int n;
    n = 0;
    while ((exp_out.size() != 0 || (!out_only && exp_hdr.size() != 0)) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s: %0d words and %0d responses still outstanding, expected 0", name, exp_out.size(), exp_hdr.size());
    end
  endtask
  initial begin
    logic [pw-1:0] e;
    bit saw;
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [pw-1:0] e;
    bit saw;
    io_cmd_v_i = 1'b0;
    io_cmd_header_i = '0;
    io_cmd_data_i = '0;
    io_resp_yumi_i = 1'b1;
    stream_yumi_i = 1'b1;
    stream_v_i = 1'b0;
    stream_data_i = '0;
    repeat (3) @(negedge clk_i);
    check("cmd_ready_in_reset", pw'(io_cmd_ready_o), 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("cmd_ready_after_reset", pw'(io_cmd_ready_o), 1);
    check("stream_v_reset", pw'(stream_v_o), 0);
    check("resp_v_reset", pw'(io_resp_v_o), 0);
    check("stream_ready_reset", pw'(stream_ready_o), 0);
    send_cmd(mk(40'h12_3456_7890, 3'd3, 4'd0), '0, pw'(64'h01234567_DEADBEEF));
    wait_idle("rd8_frame", 1'b1);
    push_in(32'hDEADBEEF);
    push_in(32'h01234567);
    check("rd_latency", pw'(io_resp_v_o), 1);
    wait_idle("rd8_done", 1'b0);
    send_cmd(mk(40'h00_0000_1000, 3'd2, 4'd1), pw'(32'hCAFEF00D), '0);
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      saw |= stream_ready_o;
    end
    check("wr_no_stream_ready", pw'(saw), 0);
    wait_idle("wr4_done", 1'b0);
    e = '0;
    for (int i = 0; i < 16; i++) e[i*32 +: 32] = 32'(i);
    send_cmd(mk(40'h80_0000_0040, 3'd6, 4'd2), '0, e);
    for (int i = 0; i < 16; i++) push_in(32'(i));
    wait_idle("rd64_done", 1'b0);
    for (int k = 0; k < 18; k++) send_cmd(mk(40'(k*64), 3'd3, 4'd0), '0, pw'({32'(32'hA000 + k), 32'(k)}));
    repeat (80) @(negedge clk_i);
    check("frames_withheld_words", pw'(exp_out.size()), 6);
    check("cmd_ready_full", pw'(io_cmd_ready_o), 0);
    push_in(32'h0);
    push_in(32'hA000);
    repeat (20) @(negedge clk_i);
    check("unblocked_words", pw'(exp_out.size()), 3);
    check("cmd_ready_unblocked", pw'(io_cmd_ready_o), 1);
    for (int k = 1; k < 18; k++) begin
      push_in(32'(k));
      push_in(32'(32'hA000 + k));
    end
    wait_idle("outstanding_done", 1'b0);
    send_cmd(mk(40'h200, 3'd3, 4'd0), '0, pw'(64'hBBBB0000_AAAA0000));
    send_cmd(mk(40'h300, 3'd3, 4'd3), pw'(64'h11112222_33334444), '0);
    repeat (30) @(negedge clk_i);
    check("wr_waits_for_rd", pw'(io_resp_v_o), 0);
    check("resp_pending", pw'(exp_hdr.size()), 2);
    push_in(32'hAAAA0000);
    push_in(32'hBBBB0000);
    wait_idle("order_done", 1'b0);
    e = '0;
    for (int i = 0; i < 16; i++) e[i*32 +: 32] = 32'(i) * 32'h01010101;
    send_cmd(mk(40'h400, 3'd6, 4'd1), e, '0);
    repeat (6) @(negedge clk_i);
    reset_i = 1'b1;
    exp_out.delete();
    exp_hdr.delete();
    exp_data.delete();
    @(negedge clk_i);
    check("stream_v_after_mid_reset", pw'(stream_v_o), 0);
    check("resp_v_after_mid_reset", pw'(io_resp_v_o), 0);
    reset_i = 1'b0;
    @(negedge clk_i);
    send_cmd(mk(40'h500, 3'd3, 4'd2), '0, pw'(64'h55556666_77778888));
    wait_idle("post_reset_frame", 1'b1);
    push_in(32'h77778888);
    push_in(32'h55556666);
    wait_idle("post_reset_done", 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
